// File: rtl/cr_huf_comp_is_long_hist.sv
`default_nettype none
// ============================================================================
//  Module   : cr_huf_comp_is_long_hist
//  Purpose  : Long-symbol histogram stage of the Huffman compressor. Pops
//             entries from the long-symbol staging FIFO, counts each 8-bit
//             long symbol into a saturating per-block histogram and, at
//             end-of-block, streams the histogram one bin per beat to the
//             tree builder, clearing each bin as it is sent.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             sc_is_long_vld/_intf     - FIFO head valid and head entry
//             is_sc_long_rd            - pop strobe to the FIFO
//             hist_vld/rdy/sym/cnt/
//             hist_seq_id/hist_last    - histogram dump stream
//             sym_err, seq_err         - one-cycle error pulses
//  Revision : 1.0 - initial release
// ============================================================================

package cr_huf_comp_is_long_hist_pkg;
   // FIFO head entry; cnt[0] marks a symbol present, eob != 0 closes a block
   typedef struct packed {
      logic [2:0] cnt;
      logic [7:0] long;
      logic [3:0] seq_id;
      logic [1:0] eob;
   } s_sc_is_long_intf;
endpackage

module cr_huf_comp_is_long_hist
   import cr_huf_comp_is_long_hist_pkg::*;
#(
   parameter int NUM_SYM = 256,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sc_is_long_vld,
   input  s_sc_is_long_intf sc_is_long_intf,
   output logic             is_sc_long_rd,
   output logic             hist_vld,
   input  logic             hist_rdy,
   output logic [7:0]       hist_sym,
   output logic [CNT_W-1:0] hist_cnt,
   output logic [3:0]       hist_seq_id,
   output logic             hist_last,
   output logic             sym_err,
   output logic             seq_err
);

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_DUMP  = 1'b1
   } state_e;

   localparam logic [8:0]       C_NUM_SYM  = 9'(NUM_SYM);
   localparam logic [7:0]       C_LAST_IDX = 8'(NUM_SYM - 1);
   localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

   state_e           state_q,       state_d;
   logic [CNT_W-1:0] cnt_q [NUM_SYM];
   logic [CNT_W-1:0] cnt_d [NUM_SYM];
   logic [7:0]       idx_q,         idx_d;
   logic             blk_start_q,   blk_start_d;
   logic [3:0]       blk_seq_id_q,  blk_seq_id_d;
   logic             sym_err_q,     sym_err_d;
   logic             seq_err_q,     seq_err_d;

   logic pop;
   logic present;
   logic sym_ok;
   logic accept;
   logic last_idx;
   logic unused_cnt_hi;

   // Upper cnt bits carry nothing this stage needs
   assign unused_cnt_hi = ^sc_is_long_intf.cnt[2:1];

   // Pop whenever the head is valid in ACCUM; held off while reset is asserted
   assign pop      = ~rst & (state_q == ST_ACCUM) & sc_is_long_vld;
   assign present  = sc_is_long_intf.cnt[0];
   assign sym_ok   = ({1'b0, sc_is_long_intf.long} < C_NUM_SYM);
   assign accept   = (state_q == ST_DUMP) & hist_rdy;
   assign last_idx = (idx_q == C_LAST_IDX);

   // Bin counters: saturating increment on a counted pop, clear on an
   // accepted dump beat. The two never coincide since they are state-exclusive.
   always_comb begin
      for (int i = 0; i < NUM_SYM; i++) begin
         cnt_d[i] = cnt_q[i];
         if (pop && present && (sc_is_long_intf.long == 8'(i)) &&
             (cnt_q[i] != C_CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + C_CNT_ONE;
         end
         if (accept && (idx_q == 8'(i))) begin
            cnt_d[i] = '0;
         end
      end
   end

   // Next-state and control
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      blk_start_d  = blk_start_q;
      blk_seq_id_d = blk_seq_id_q;
      sym_err_d    = 1'b0;
      seq_err_d    = 1'b0;

      case (state_q)
         ST_ACCUM: begin
            if (pop) begin
               if (blk_start_q) begin
                  blk_seq_id_d = sc_is_long_intf.seq_id;
                  blk_start_d  = 1'b0;
               end else if (sc_is_long_intf.seq_id != blk_seq_id_q) begin
                  seq_err_d = 1'b1;
               end
               if (present && !sym_ok) begin
                  sym_err_d = 1'b1;
               end
               if (sc_is_long_intf.eob != 2'b00) begin
                  state_d = ST_DUMP;
                  idx_d   = '0;
               end
            end
         end
         ST_DUMP: begin
            if (hist_rdy) begin
               if (last_idx) begin
                  state_d     = ST_ACCUM;
                  blk_start_d = 1'b1;
                  idx_d       = '0;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_ACCUM;
         for (int i = 0; i < NUM_SYM; i++) begin
            cnt_q[i] <= '0;
         end
         idx_q        <= '0;
         blk_start_q  <= 1'b1;
         blk_seq_id_q <= '0;
         sym_err_q    <= 1'b0;
         seq_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         blk_start_q  <= blk_start_d;
         blk_seq_id_q <= blk_seq_id_d;
         sym_err_q    <= sym_err_d;
         seq_err_q    <= seq_err_d;
      end
   end

   // Dump stream is a pure function of registered state, so it holds while stalled
   always_comb begin
      hist_cnt = '0;
      for (int i = 0; i < NUM_SYM; i++) begin
         if (idx_q == 8'(i)) begin
            hist_cnt = cnt_q[i];
         end
      end
   end

   assign is_sc_long_rd = pop;
   assign hist_vld      = (state_q == ST_DUMP);
   assign hist_sym      = idx_q;
   assign hist_seq_id   = blk_seq_id_q;
   assign hist_last     = hist_vld & last_idx;
   assign sym_err       = sym_err_q;
   assign seq_err       = seq_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cr_huf_comp_is_long_hist.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cr_huf_comp_is_long_hist
//  Purpose  : Directed self-checking bench for cr_huf_comp_is_long_hist.
//             Main instance uses NUM_SYM=256/CNT_W=16; a second instance
//             uses NUM_SYM=16 for the out-of-range symbol case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cr_huf_comp_is_long_hist;
   import cr_huf_comp_is_long_hist_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b1;

   // main instance
   logic             vld = 1'b0;
   s_sc_is_long_intf intf = '0;
   logic             rd;
   logic             hist_vld;
   logic             hist_rdy = 1'b0;
   logic [7:0]       hist_sym;
   logic [15:0]      hist_cnt;
   logic [3:0]       hist_seq_id;
   logic             hist_last;
   logic             sym_err;
   logic             seq_err;

   // small instance
   logic             b_vld = 1'b0;
   s_sc_is_long_intf b_intf = '0;
   logic             b_rd;
   logic             b_hist_vld;
   logic             b_hist_rdy = 1'b0;
   logic [7:0]       b_hist_sym;
   logic [15:0]      b_hist_cnt;
   logic [3:0]       b_hist_seq_id;
   logic             b_hist_last;
   logic             b_sym_err;
   logic             b_seq_err;

   int               n_checks = 0;
   int               n_errs   = 0;
   int               exp_hist [256];
   s_sc_is_long_intf hold_ent = '0;

   always #5 clk = ~clk;

   cr_huf_comp_is_long_hist #(.NUM_SYM(256), .CNT_W(16)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .sc_is_long_vld  (vld),
      .sc_is_long_intf (intf),
      .is_sc_long_rd   (rd),
      .hist_vld        (hist_vld),
      .hist_rdy        (hist_rdy),
      .hist_sym        (hist_sym),
      .hist_cnt        (hist_cnt),
      .hist_seq_id     (hist_seq_id),
      .hist_last       (hist_last),
      .sym_err         (sym_err),
      .seq_err         (seq_err)
   );

   cr_huf_comp_is_long_hist #(.NUM_SYM(16), .CNT_W(16)) u_dut16 (
      .clk             (clk),
      .rst             (rst),
      .sc_is_long_vld  (b_vld),
      .sc_is_long_intf (b_intf),
      .is_sc_long_rd   (b_rd),
      .hist_vld        (b_hist_vld),
      .hist_rdy        (b_hist_rdy),
      .hist_sym        (b_hist_sym),
      .hist_cnt        (b_hist_cnt),
      .hist_seq_id     (b_hist_seq_id),
      .hist_last       (b_hist_last),
      .sym_err         (b_sym_err),
      .seq_err         (b_seq_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_exp();
      foreach (exp_hist[i]) exp_hist[i] = 0;
   endtask

   // Present one FIFO head entry for one cycle (driven at negedge, sampled #1 later)
   task automatic push(input logic pres, input logic [7:0] sym, input logic [3:0] seq,
                       input logic [1:0] eob, input bit chk_rd);
      @(negedge clk);
      vld         = 1'b1;
      intf.cnt    = {2'b00, pres};
      intf.long   = sym;
      intf.seq_id = seq;
      intf.eob    = eob;
      #1;
      if (chk_rd) check("pop", rd, 1);
   endtask

   // Walk a full 256-beat dump against exp_hist. With hold set, the FIFO shows
   // hold_ent throughout and must be popped exactly in the cycle after the dump.
   task automatic dump_check(input logic [3:0] exp_seq, input bit rnd, input bit hold);
      int beat = 0;
      int cyc  = 0;
      while (beat < 256 && cyc < 4000) begin
         @(negedge clk);
         hist_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         vld      = hold;
         intf     = hold_ent;
         #1;
         cyc++;
         check("dump_vld",   hist_vld,    1);
         check("dump_sym",   hist_sym,    beat);
         check("dump_cnt",   hist_cnt,    exp_hist[beat]);
         check("dump_seq",   hist_seq_id, exp_seq);
         check("dump_last",  hist_last,   (beat == 255));
         check("dump_nopop", rd,          0);
         if (hist_rdy) beat++;
      end
      check("dump_done", beat, 256);
      @(negedge clk);
      hist_rdy = 1'b1;
      #1;
      check("post_dump_vld", hist_vld, 0);
      check("post_dump_pop", rd,       hold);
   endtask

   initial begin
      #20000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      // ---------------- reset and idle ----------------
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_rd",      rd,          0);
      check("rst_vld",     hist_vld,    0);
      check("rst_last",    hist_last,   0);
      check("rst_sym",     hist_sym,    0);
      check("rst_cnt",     hist_cnt,    0);
      check("rst_seq",     hist_seq_id, 0);
      check("rst_sym_err", sym_err,     0);
      check("rst_seq_err", seq_err,     0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         check("idle_rd",  rd,                0);
         check("idle_vld", hist_vld,          0);
         check("idle_err", {sym_err, seq_err}, 0);
      end

      // ---------------- 5,5,5,200 block ----------------
      hist_rdy = 1'b1;
      push(1'b1, 8'd5,   4'd3, 2'd0, 1'b1);
      push(1'b1, 8'd5,   4'd3, 2'd0, 1'b1);
      push(1'b1, 8'd5,   4'd3, 2'd0, 1'b1);
      push(1'b1, 8'd200, 4'd3, 2'd1, 1'b1);
      clear_exp();
      exp_hist[5]   = 3;
      exp_hist[200] = 1;
      dump_check(4'd3, 1'b0, 1'b0);

      // ---------------- empty block: all bins cleared ----------------
      push(1'b0, 8'd0, 4'd6, 2'd1, 1'b1);
      clear_exp();
      dump_check(4'd6, 1'b0, 1'b0);

      // ---------------- random back-pressure, FIFO held non-empty ----------------
      push(1'b1, 8'd10,  4'd1, 2'd0, 1'b1);
      push(1'b1, 8'd11,  4'd1, 2'd0, 1'b1);
      push(1'b1, 8'd10,  4'd1, 2'd0, 1'b1);
      push(1'b1, 8'd255, 4'd1, 2'd2, 1'b1);
      clear_exp();
      exp_hist[10]  = 2;
      exp_hist[11]  = 1;
      exp_hist[255] = 1;
      hold_ent = '{cnt: 3'b001, long: 8'd42, seq_id: 4'd9, eob: 2'd0};
      dump_check(4'd1, 1'b1, 1'b1);
      hold_ent = '0;
      push(1'b0, 8'd0, 4'd9, 2'd1, 1'b1);
      check("no_seq_err", seq_err, 0);
      clear_exp();
      exp_hist[42] = 1;
      dump_check(4'd9, 1'b0, 1'b0);

      // ---------------- saturation ----------------
      for (int k = 0; k < 65537; k++) push(1'b1, 8'd7, 4'd2, 2'd0, 1'b0);
      push(1'b0, 8'd0, 4'd2, 2'd1, 1'b1);
      clear_exp();
      exp_hist[7] = 65535;
      dump_check(4'd2, 1'b0, 1'b0);

      // ---------------- reset mid-dump at index 100 ----------------
      push(1'b1, 8'd1,   4'd0, 2'd0, 1'b1);
      push(1'b1, 8'd150, 4'd0, 2'd1, 1'b1);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         vld      = 1'b0;
         hist_rdy = 1'b1;
         #1;
         check("pre_rst_sym", hist_sym, k);
         check("pre_rst_cnt", hist_cnt, (k == 1) ? 1 : 0);
      end
      @(negedge clk);
      hist_rdy = 1'b0;
      rst      = 1'b1;
      #1;
      check("rst_at_sym", hist_sym, 100);
      @(negedge clk);
      rst      = 1'b0;
      hist_rdy = 1'b1;
      #1;
      check("mid_rst_vld", hist_vld, 0);
      check("mid_rst_sym", hist_sym, 0);
      push(1'b0, 8'd0, 4'd5, 2'd1, 1'b1);
      clear_exp();
      dump_check(4'd5, 1'b0, 1'b0);
      vld = 1'b0;

      // ---------------- NUM_SYM=16 instance: sym_err and seq_err ----------------
      @(negedge clk);
      b_vld  = 1'b1;
      b_intf = '{cnt: 3'b001, long: 8'd20, seq_id: 4'd2, eob: 2'd0};
      #1;
      check("b_pop0", b_rd, 1);
      @(negedge clk);
      b_intf = '{cnt: 3'b000, long: 8'd0, seq_id: 4'd4, eob: 2'd1};
      #1;
      check("b_pop1",      b_rd,      1);
      check("b_sym_err_1", b_sym_err, 1);
      check("b_seq_err_0", b_seq_err, 0);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         b_vld      = 1'b0;
         b_hist_rdy = 1'b1;
         #1;
         if (k == 0) begin
            check("b_sym_err_once", b_sym_err, 0);
            check("b_seq_err_1",    b_seq_err, 1);
         end
         if (k == 1) check("b_seq_err_once", b_seq_err, 0);
         check("b_dump_vld",  b_hist_vld,    1);
         check("b_dump_sym",  b_hist_sym,    k);
         check("b_dump_cnt",  b_hist_cnt,    0);
         check("b_dump_seq",  b_hist_seq_id, 2);
         check("b_dump_last", b_hist_last,   (k == 15));
      end
      @(negedge clk);
      #1;
      check("b_post_vld", b_hist_vld, 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
